// File: rtl/sha2_pkg.sv
// Shared constants and state encoding for the SHA-2 message padder.
package sha2_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_OUT   = 2'd1,
    ST_EXTRA = 2'd2
  } sha2_state_e;

  localparam logic [7:0] PAD_BYTE        = 8'h80;
  localparam int         SHA256_WORDSIZE = 32;
  localparam int         SHA512_WORDSIZE = 64;

endpackage

// File: rtl/sha2_pad_word.sv
// Byte-masks one message word and merges the 0x80 marker right after the last valid byte.
// nbytes == 0 means a full word: the data passes through untouched.
module sha2_pad_word
  import sha2_pkg::*;
#(
  parameter  int WORDSIZE = 32,
  localparam int NB       = WORDSIZE / 8,
  localparam int BW       = $clog2(NB)
) (
  input  logic [WORDSIZE-1:0] data,
  input  logic [BW-1:0]       nbytes,
  output logic [WORDSIZE-1:0] padded
);

  always_comb begin
    padded = data;
    if (nbytes != '0) begin
      // Byte 0 is the MSB byte; bytes past the marker are cleared.
      for (int b = 0; b < NB; b++) begin
        if (b == int'(nbytes)) padded[WORDSIZE-1-8*b -: 8] = PAD_BYTE;
        else if (b > int'(nbytes)) padded[WORDSIZE-1-8*b -: 8] = 8'h00;
      end
    end
  end

endmodule

// File: rtl/sha2_padder.sv
// SHA-2 message padder: packs words into 16-word blocks, appends 0x80 and the bit length.
// Define SHA2_PADDER_BYTE_EN to add the in_bytes port for partial last words.
module sha2_padder
  import sha2_pkg::*;
#(
  parameter  int WORDSIZE = SHA256_WORDSIZE,
  localparam int BW       = $clog2(WORDSIZE / 8)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [WORDSIZE-1:0]    in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_last,
`ifdef SHA2_PADDER_BYTE_EN
  input  logic [BW-1:0]          in_bytes,
`endif
  output logic [WORDSIZE*16-1:0] blk,
  output logic                   blk_valid,
  input  logic                   blk_ready,
  output logic                   blk_last,
  output logic [1:0]             dbg_state
);

  localparam logic [1:0] S_FILL  = ST_FILL;
  localparam logic [1:0] S_OUT   = ST_OUT;
  localparam logic [1:0] S_EXTRA = ST_EXTRA;
  localparam logic [WORDSIZE-1:0] MARK = {PAD_BYTE, {(WORDSIZE-8){1'b0}}};

  logic [1:0]            state_q;
  logic                  rdy_q;
  logic [3:0]            idx_q;
  logic [2*WORDSIZE-1:0] len_q;
  logic [WORDSIZE-1:0]   w_q [16];
  logic                  last_q;
  logic                  extra_q;
  logic                  mark_q;

  logic                  partial;
  logic [BW-1:0]         nbytes_w;
  logic [WORDSIZE-1:0]   pad_w;
  logic [2*WORDSIZE-1:0] add_len;
  logic [2*WORDSIZE-1:0] len_nx;
  logic [4:0]            mark_idx;

`ifdef SHA2_PADDER_BYTE_EN
  assign partial  = in_last && (in_bytes != '0);
  assign nbytes_w = in_last ? in_bytes : '0;
  assign add_len  = partial ? ((2*WORDSIZE)'(in_bytes) << 3) : (2*WORDSIZE)'(WORDSIZE);
`else
  assign partial  = 1'b0;
  assign nbytes_w = '0;
  assign add_len  = (2*WORDSIZE)'(WORDSIZE);
`endif

  sha2_pad_word #(.WORDSIZE(WORDSIZE)) u_pad (
    .data   (in_data),
    .nbytes (nbytes_w),
    .padded (pad_w)
  );

  assign len_nx   = len_q + add_len;
  // A partial word carries its own marker; a full word pushes it to the next index (maybe 16).
  assign mark_idx = partial ? {1'b0, idx_q} : ({1'b0, idx_q} + 5'd1);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid and payload stay stable until that edge, and ready never depends on valid.
  assign in_ready  = rdy_q && (state_q == S_FILL);
  assign blk_valid = (state_q == S_OUT);
  assign blk_last  = last_q;
  assign dbg_state = state_q;

  for (genvar g = 0; g < 16; g++) begin : g_blk
    assign blk[WORDSIZE*(16-g)-1 -: WORDSIZE] = w_q[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FILL;
      rdy_q   <= 1'b0;
      idx_q   <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      extra_q <= 1'b0;
      mark_q  <= 1'b0;
      for (int i = 0; i < 16; i++) w_q[i] <= '0;
    end else begin
      rdy_q <= 1'b1;
      case (state_q)
        S_FILL: begin
          if (in_valid && rdy_q) begin
            len_q <= len_nx;
            idx_q <= idx_q + 4'd1;
            if (!in_last) begin
              w_q[idx_q] <= in_data;
              if (idx_q == 4'd15) begin
                last_q  <= 1'b0;
                state_q <= S_OUT;
              end
            end else begin
              for (int i = 0; i < 16; i++) begin
                if (i > int'(idx_q)) w_q[i] <= (i == int'(mark_idx)) ? MARK : '0;
              end
              w_q[idx_q] <= pad_w;
              if (mark_idx <= 5'd13) begin
                w_q[14] <= len_nx[2*WORDSIZE-1 -: WORDSIZE];
                w_q[15] <= len_nx[WORDSIZE-1:0];
                last_q  <= 1'b1;
              end else begin
                last_q  <= 1'b0;
                extra_q <= 1'b1;
                mark_q  <= mark_idx[4];
              end
              state_q <= S_OUT;
            end
          end
        end
        S_OUT: begin
          if (blk_ready) begin
            last_q <= 1'b0;
            if (extra_q) begin
              state_q <= S_EXTRA;
            end else begin
              state_q <= S_FILL;
              if (last_q) begin
                idx_q <= '0;
                len_q <= '0;
              end
            end
          end
        end
        S_EXTRA: begin
          for (int i = 0; i < 16; i++) w_q[i] <= '0;
          w_q[0]  <= mark_q ? MARK : '0;
          w_q[14] <= len_q[2*WORDSIZE-1 -: WORDSIZE];
          w_q[15] <= len_q[WORDSIZE-1:0];
          last_q  <= 1'b1;
          extra_q <= 1'b0;
          mark_q  <= 1'b0;
          state_q <= S_OUT;
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_padder.sv
// Bench for sha2_padder (SHA-256 width): random messages against a byte-level padding model.
module tb_sha2_padder;

  localparam int W    = 32;
  localparam int BLKW = 16 * W;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [W-1:0]    in_data = '0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic            in_last = 1'b0;
`ifdef SHA2_PADDER_BYTE_EN
  logic [1:0]      in_bytes = '0;
`endif
  logic [BLKW-1:0] blk;
  logic            blk_valid;
  logic            blk_ready = 1'b0;
  logic            blk_last;
  logic [1:0]      dbg_state;

  logic [BLKW-1:0] exp_q[$];
  logic            exp_last_q[$];
  logic [BLKW-1:0] cons_exp;
  logic            cons_exp_last;
  int              n_checks = 0;
  int              n_errors = 0;
  bit              cons_en = 1'b0;

  sha2_padder #(.WORDSIZE(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
`ifdef SHA2_PADDER_BYTE_EN
    .in_bytes  (in_bytes),
`endif
    .blk       (blk),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_last  (blk_last),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [BLKW-1:0] got, input logic [BLKW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Standard SHA-256 padding on a byte stream, then cut into 64-byte blocks.
  task automatic model(input logic [7:0] msg[$]);
    logic [7:0]  p[$];
    logic [63:0] bitlen;
    logic [BLKW-1:0] b;
    int nblk;
    p = msg;
    bitlen = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bitlen[8*k +: 8]);
    nblk = p.size() / 64;
    for (int i = 0; i < nblk; i++) begin
      b = '0;
      for (int j = 0; j < 64; j++) b = {b[BLKW-9:0], p[64*i+j]};
      exp_q.push_back(b);
      exp_last_q.push_back(i == nblk - 1);
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_word(input logic [W-1:0] d, input bit last, input logic [1:0] nb);
    int  t;
    bit  done;
    t = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        in_data  = $urandom;
      end else begin
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
`ifdef SHA2_PADDER_BYTE_EN
        in_bytes = nb;
`endif
        done = in_ready;
      end
      t++;
      if (!done && t > 500) begin
        check("in_timeout", 0, 1);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_msg(input int n, input bit abc);
    logic [7:0] m[$];
    logic [W-1:0] d;
    logic [7:0]   by;
    logic [1:0]   nb;
    int nw;
    m = {};
    for (int i = 0; i < n; i++) m.push_back(abc ? 8'(8'h61 + i) : 8'($urandom));
    model(m);
    nw = (n + 3) / 4;
    for (int j = 0; j < nw; j++) begin
      d = '0;
      for (int k = 0; k < 4; k++) begin
        by = (4*j + k < n) ? m[4*j+k] : 8'($urandom);
        d = {d[W-9:0], by};
      end
      nb = (j == nw - 1) ? 2'(n % 4) : 2'($urandom);
      drive_word(d, j == nw - 1, nb);
    end
    idle();
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) check("drain", exp_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  // ---------------- scoreboard consumer ----------------
  // Ready is chosen first, then the block that will transfer on the coming edge is checked.
  always @(negedge clk) begin
    blk_ready = cons_en ? ($urandom_range(0, 9) < 7) : 1'b0;
    if (rst_n && blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_blk", 1, 0);
      end else begin
        cons_exp      = exp_q.pop_front();
        cons_exp_last = exp_last_q.pop_front();
        check("blk", blk, cons_exp);
        check("blk_last", blk_last, cons_exp_last);
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [BLKW-1:0] snap;
    int t;
    int n;
`ifdef SHA2_PADDER_BYTE_EN
    int dir_len[8] = '{3, 55, 56, 64, 1, 61, 63, 119};
`else
    int dir_len[8] = '{4, 52, 56, 64, 60, 8, 120, 128};
`endif

    repeat (3) @(negedge clk);
    check("rst_blk", blk, 0);
    check("rst_blk_valid", blk_valid, 0);
    check("rst_blk_last", blk_last, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1);
    cons_en = 1'b1;

    for (int i = 0; i < 8; i++) send_msg(dir_len[i], i == 0);
    for (int i = 0; i < 25; i++) begin
`ifdef SHA2_PADDER_BYTE_EN
      n = $urandom_range(1, 160);
`else
      n = 4 * $urandom_range(1, 40);
`endif
      send_msg(n, 1'b0);
    end
    drain();

    // Stall a completed block for five cycles while junk words are offered.
    cons_en = 1'b0;
    @(negedge clk);
    send_msg(64, 1'b0);
    t = 0;
    while (!blk_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("stall_reach_out", blk_valid, 1);
    snap = blk;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_last  = 1'b0;
      in_data  = $urandom;
      check("stall_blk", blk, snap);
      check("stall_blk_valid", blk_valid, 1);
      check("stall_in_ready", in_ready, 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    cons_en  = 1'b1;
    drain();
    send_msg(24, 1'b0);
    drain();

    // Abandon a message after 7 words with an asynchronous reset.
    for (int j = 0; j < 7; j++) drive_word($urandom, 1'b0, 2'd0);
    idle();
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_blk", blk, 0);
    check("mid_rst_blk_valid", blk_valid, 0);
    check("mid_rst_blk_last", blk_last, 0);
    check("mid_rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
`ifdef SHA2_PADDER_BYTE_EN
    send_msg(3, 1'b1);
`else
    send_msg(4, 1'b1);
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
